// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types for the multi-channel ADC capture controller.
// Capture FSM encoding and trigger slope selectors.
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } state_t;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Circular sample buffer write port.
// The controller drives it; the external RAM receives it.
interface adc_capture_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 16
);

  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;

  modport master (
    output buf_we,
    output buf_addr,
    output buf_wdata
  );

  modport slave (
    input buf_we,
    input buf_addr,
    input buf_wdata
  );

endinterface

// File: rtl/adc_trig_detect.sv
// Level/slope trigger on one selected channel of the S1 sample.
// Tracks the previous accepted sample; hit is combinational.
module adc_trig_detect
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     upd,
  input  logic [NUM_CH*DATA_W-1:0] sample,
  input  logic [1:0]               ch,
  input  logic                     slope,
  input  logic [DATA_W-1:0]        level,
  output logic                     trig_hit
);

  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] prev;
  logic              prev_ok;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 2'(i)) cur = sample[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (clr) begin
      prev_ok <= 1'b0;
    end else if (upd) begin
      prev    <= cur;
      prev_ok <= 1'b1;
    end
  end

  always_comb begin
    trig_hit = 1'b0;
    if (prev_ok) begin
      if (slope == SLOPE_RISE)
        trig_hit = (prev < level) && (cur >= level);
      else
        trig_hit = (prev >= level) && (cur < level);
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: decimation, pre/post trigger
// capture into a circular buffer via the write port.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int DEC_W  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = NUM_CH * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DEC_W-1:0]  cfg_decim,
  input  logic [AW-1:0]     cfg_pre,
  input  logic [AW-1:0]     cfg_post,
  input  logic [1:0]        cfg_trig_ch,
  input  logic              cfg_slope,
  input  logic [DATA_W-1:0] cfg_level,
  adc_capture_ctrl_if.master bus,
  output logic [AW-1:0]     trig_addr,
  output logic [AW-1:0]     start_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CW = AW + 2;

  state_t            state;
  state_t            state_nx;
  logic [DW-1:0]     s1;
  logic [DEC_W-1:0]  dec_cnt;
  logic [DEC_W-1:0]  decim_q;
  logic [AW-1:0]     pre_q;
  logic [AW-1:0]     post_q;
  logic [AW-1:0]     pre_cnt;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     addr;
  logic [1:0]        ch_q;
  logic              slope_q;
  logic [DATA_W-1:0] level_q;
  logic              force_pend;
  logic [CW-1:0]     need;
  logic              cfg_bad;
  logic              accept;
  logic              trig_hit;
  logic              wr;
  logic              fire;
  logic              go;
  logic              err;

  assign busy       = (state == PRE) || (state == WAIT) || (state == POST);
  assign done       = (state == DONE);
  assign accept     = busy && (dec_cnt == '0);
  assign need       = CW'(cfg_pre) + CW'(cfg_post) + CW'(1);
  assign cfg_bad    = need > CW'(DEPTH);
  assign start_addr = trig_addr - pre_q;

  adc_trig_detect #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_trig (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (go),
    .upd      (accept),
    .sample   (s1),
    .ch       (ch_q),
    .slope    (slope_q),
    .level    (level_q),
    .trig_hit (trig_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    fire     = 1'b0;
    go       = 1'b0;
    err      = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (arm) begin
            if (cfg_bad) begin
              err = 1'b1;
            end else begin
              go       = 1'b1;
              state_nx = (cfg_pre == '0) ? WAIT : PRE;
            end
          end
        end
        PRE: begin
          if (accept) begin
            wr = 1'b1;
            if (pre_cnt == pre_q - AW'(1)) state_nx = WAIT;
          end
        end
        WAIT: begin
          if (accept) begin
            wr = 1'b1;
            if (trig_hit || force_trig || force_pend) begin
              fire     = 1'b1;
              state_nx = (post_q == '0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (accept) begin
            wr = 1'b1;
            if (post_cnt == post_q - AW'(1)) state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Config is captured only on an accepted arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      ch_q    <= '0;
      slope_q <= SLOPE_RISE;
      level_q <= '0;
    end else if (go) begin
      decim_q <= cfg_decim;
      pre_q   <= cfg_pre;
      post_q  <= cfg_post;
      ch_q    <= cfg_trig_ch;
      slope_q <= cfg_slope;
      level_q <= cfg_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      dec_cnt    <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      addr       <= '0;
      trig_addr  <= '0;
      force_pend <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      s1      <= adc_data;
      cfg_err <= err;
      if (go)
        dec_cnt <= '0;
      else if (busy)
        dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_W'(1);
      if (go)
        pre_cnt <= '0;
      else if (wr && state == PRE)
        pre_cnt <= pre_cnt + AW'(1);
      if (fire)
        post_cnt <= '0;
      else if (wr && state == POST)
        post_cnt <= post_cnt + AW'(1);
      if (go)
        addr <= '0;
      else if (wr)
        addr <= addr + AW'(1);
      if (fire)
        trig_addr <= addr;
      if (go || abort || fire)
        force_pend <= 1'b0;
      else if (state == WAIT && force_trig)
        force_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.buf_we    <= 1'b0;
      bus.buf_addr  <= '0;
      bus.buf_wdata <= '0;
    end else begin
      bus.buf_we <= wr;
      if (wr) begin
        bus.buf_addr  <= addr;
        bus.buf_wdata <= s1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (2 ch x 8 bit, depth 1024).
// Ch1 is held at 0xA5; ch0 carries ramps and steps.
module tb_adc_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ch0;
  logic [7:0]  ch1;
  logic [15:0] adc_data;
  logic        arm;
  logic        abort;
  logic        force_trig;
  logic [15:0] cfg_decim;
  logic [9:0]  cfg_pre;
  logic [9:0]  cfg_post;
  logic [1:0]  cfg_trig_ch;
  logic        cfg_slope;
  logic [7:0]  cfg_level;
  logic [9:0]  trig_addr;
  logic [9:0]  start_addr;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int total;
  int bad;
  int wr_cnt;
  int cyc;
  int last_cyc;
  int last_gap;
  int first_addr;
  logic ramp_on;
  logic [15:0] mem [0:1023];

  adc_capture_ctrl_if #(.AW(10), .DW(16)) bus ();

  assign adc_data = {ch1, ch0};

  adc_capture_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_data    (adc_data),
    .arm         (arm),
    .abort       (abort),
    .force_trig  (force_trig),
    .cfg_decim   (cfg_decim),
    .cfg_pre     (cfg_pre),
    .cfg_post    (cfg_post),
    .cfg_trig_ch (cfg_trig_ch),
    .cfg_slope   (cfg_slope),
    .cfg_level   (cfg_level),
    .bus         (bus),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.buf_we === 1'b1) begin
      mem[bus.buf_addr] = bus.buf_wdata;
      if (wr_cnt == 0) first_addr = int'(bus.buf_addr);
      last_gap = cyc - last_cyc;
      last_cyc = cyc;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) ch0 = ch0 + 8'h10;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("done", 32'(done), 1);
    repeat (2) tick();
  endtask

  task automatic setup(input int dec, input int pre, input int post,
                       input logic slope, input logic [7:0] lvl);
    cfg_decim   = 16'(dec);
    cfg_pre     = 10'(pre);
    cfg_post    = 10'(post);
    cfg_trig_ch = 2'd0;
    cfg_slope   = slope;
    cfg_level   = lvl;
    wr_cnt      = 0;
    first_addr  = 'hFFFF;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; wr_cnt = 0; cyc = 0; last_cyc = 0;
    last_gap = 0; first_addr = 0; ramp_on = 1'b0;
    ch0 = 8'h00; ch1 = 8'hA5;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    setup(0, 0, 0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_we", 32'(bus.buf_we), 0);
    chk("rst_addr", 32'(bus.buf_addr), 0);
    chk("rst_trig", 32'(trig_addr), 0);
    chk("rst_start", 32'(start_addr), 0);
    rst_n = 1'b1;
    tick();

    // 1: rising ramp, pre 4 post 3, samples 0x40.. from arm
    setup(0, 4, 3, 1'b0, 8'h80);
    ramp_on = 1'b1;
    ch0 = 8'h40;
    do_arm();
    chk("t1_we0", 32'(bus.buf_we), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_we1", 32'(bus.buf_we), 1);
    chk("t1_addr1", 32'(bus.buf_addr), 0);
    chk("t1_data1", 32'(bus.buf_wdata), 'hA540);
    wait_done(30);
    chk("t1_wrs", 32'(wr_cnt), 8);
    chk("t1_trig", 32'(trig_addr), 4);
    chk("t1_start", 32'(start_addr), 0);
    chk("t1_m4", 32'(mem[4]), 'hA580);
    chk("t1_m7", 32'(mem[7]), 'hA5B0);
    chk("t1_busy2", 32'(busy), 0);

    // 2: decimate by 3, accepted ramp steps 0x30
    setup(2, 4, 3, 1'b0, 8'h80);
    ch0 = 8'h20;
    do_arm();
    wait_done(60);
    chk("t2_wrs", 32'(wr_cnt), 12);
    chk("t2_gap", 32'(last_gap), 3);
    chk("t2_trig", 32'(trig_addr), 8);
    chk("t2_start", 32'(start_addr), 4);
    chk("t2_m0", 32'(mem[0]), 'hA520);
    chk("t2_m1", 32'(mem[1]), 'hA550);
    chk("t2_m5", 32'(mem[5]), 'hA510);
    chk("t2_m8", 32'(mem[8]), 'hA5A0);
    chk("t2_m11", 32'(mem[11]), 'hA530);

    // 3: falling, long hold so addresses wrap
    ramp_on = 1'b0;
    setup(0, 4, 2, 1'b1, 8'h40);
    ch0 = 8'h50;
    do_arm();
    repeat (2048) tick();
    chk("t3_busy", 32'(busy), 1);
    chk("t3_nodone", 32'(done), 0);
    tick();
    ch0 = 8'h30;
    wait_done(20);
    chk("t3_wrs", 32'(wr_cnt), 2053);
    chk("t3_trig", 32'(trig_addr), 2);
    chk("t3_start", 32'(start_addr), 1022);
    chk("t3_m1", 32'(mem[1]), 'hA550);
    chk("t3_m2", 32'(mem[2]), 'hA530);
    chk("t3_m4", 32'(mem[4]), 'hA530);

    // 4: oversize window rejected, exact fit accepted
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_idle_done", 32'(done), 0);
    setup(0, 600, 500, 1'b0, 8'h80);
    do_arm();
    chk("t4_err", 32'(cfg_err), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    tick();
    chk("t4_err_pulse", 32'(cfg_err), 0);
    repeat (3) tick();
    chk("t4_nowr", 32'(wr_cnt), 0);
    cfg_post = 10'd423;
    do_arm();
    chk("t4_fit_err", 32'(cfg_err), 0);
    chk("t4_fit_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", 32'(busy), 0);

    // 5: abort together with arm while in POST
    setup(0, 2, 200, 1'b0, 8'h80);
    ramp_on = 1'b1;
    ch0 = 8'h40;
    do_arm();
    repeat (10) tick();
    chk("t5_busy", 32'(busy), 1);
    chk("t5_trig", 32'(trig_addr), 4);
    abort = 1'b1;
    arm = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    chk("t5_we", 32'(bus.buf_we), 0);
    chk("t5_busy0", 32'(busy), 0);
    chk("t5_done0", 32'(done), 0);
    tick();
    chk("t5_stay", 32'(busy), 0);
    chk("t5_wrs", 32'(wr_cnt), 10);

    // 6: flat at level, forced trigger, then re-arm from DONE
    ramp_on = 1'b0;
    for (int r = 0; r < 2; r++) begin
      setup(1, 2, 1, 1'b0, 8'h80);
      ch0 = 8'h80;
      do_arm();
      repeat (5) tick();
      chk("t6_wait", 32'(busy), 1);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      wait_done(20);
      chk("t6_first", 32'(first_addr), 0);
      chk("t6_trig", 32'(trig_addr), 3);
      chk("t6_start", 32'(start_addr), 1);
      chk("t6_wrs", 32'(wr_cnt), 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
